fix_dot_product_pipe: RTL and testbench

- Parametrised, pipelined signed fixed-point dot-product engine.
- Each accepted beat multiplies LANES element pairs and sums them through a registered adder tree.
- Beats are accumulated until in_last, then the result is rounded, saturated and emitted as one WIDTH-bit word.
- Successor to the fixed-length vector multiplier: adds multi-beat accumulation, valid/ready handshake, rounding/saturation, and parametrised lane count.
- Sits between the feature/weight buffers and the activation stage of the CNN datapath.

---
 rtl/fix_pkg.sv | 56 +++++
 rtl/fix_add_tree.sv | 58 +++++
 rtl/fix_dot_product_pipe.sv | 131 +++++++++++++
 tb/tb_fix_dot_product_pipe.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fix_pkg.sv
// Shared fixed-point helpers: width derivation and round-half-up / saturate.
package fix_pkg;

   // Wide enough for any accumulator this package is asked to round (ACC_W < RS_W).
   localparam int unsigned RS_W = 128;

   typedef struct packed {
      logic [RS_W-1:0] data;
      logic            sat;
   } rs_t;

   function automatic int unsigned clog2(input int unsigned n);
      int unsigned r;
      r = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(n)) r = 32'(i + 1);
      end
      return r;
   endfunction

   function automatic int unsigned tree_w(input int unsigned in_w, input int unsigned lanes);
      return in_w + clog2(lanes);
   endfunction

   function automatic int unsigned acc_w(input int unsigned width, input int unsigned lanes,
                                         input int unsigned guard);
      return tree_w(2 * width, lanes) + guard;
   endfunction

   // Round half up by point_width fractional bits, then clip to a signed width-bit range.
   function automatic rs_t round_sat(input logic signed [RS_W-1:0] val,
                                     input int unsigned point_width,
                                     input int unsigned width);
      logic signed [RS_W-1:0] half;
      logic signed [RS_W-1:0] r;
      logic signed [RS_W-1:0] hi;
      logic signed [RS_W-1:0] lo;
      rs_t res;
      half = RS_W'(1) << (point_width - 1);
      hi   = (RS_W'(1) << (width - 1)) - RS_W'(1);
      lo   = ~hi;
      r    = (val + half) >>> point_width;
      res.sat = 1'b0;
      if (r > hi) begin
         res.data = hi;
         res.sat  = 1'b1;
      end else if (r < lo) begin
         res.data = lo;
         res.sat  = 1'b1;
      end else begin
         res.data = r;
      end
      return res;
   endfunction

endpackage

// File: rtl/fix_add_tree.sv
// Registered binary adder tree: one register level per halving, sign-growing by one bit per level.
module fix_add_tree
   import fix_pkg::*;
#(
   parameter int unsigned LANES = 8,
   parameter int unsigned IN_W  = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            en,
   input  logic                            in_valid,
   input  logic                            in_last,
   input  logic [LANES*IN_W-1:0]           in_data,
   output logic                            out_valid,
   output logic                            out_last,
   output logic [tree_w(IN_W, LANES)-1:0]  out_data
);

   localparam int unsigned LEVELS = clog2(LANES);

   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      localparam int unsigned N = LANES >> l;
      localparam int unsigned W = IN_W + l;

      logic [N*W-1:0] sum;
      logic           valid;
      logic           last;

      if (l == 0) begin : g_src
         assign sum   = in_data;
         assign valid = in_valid;
         assign last  = in_last;
      end else begin : g_add
         localparam int unsigned PW = W - 1;

         // Pairwise sum of the previous level, sign-extended so no carry is lost.
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               sum   <= '0;
               valid <= 1'b0;
               last  <= 1'b0;
            end else if (en) begin
               valid <= g_lvl[l-1].valid;
               last  <= g_lvl[l-1].last;
               for (int i = 0; i < int'(N); i++) begin
                  sum[i*W +: W] <= W'($signed(g_lvl[l-1].sum[2*i*PW +: PW]))
                                 + W'($signed(g_lvl[l-1].sum[(2*i+1)*PW +: PW]));
               end
            end
         end
      end
   end

   assign out_data  = g_lvl[LEVELS].sum;
   assign out_valid = g_lvl[LEVELS].valid;
   assign out_last  = g_lvl[LEVELS].last;

endmodule

// File: rtl/fix_dot_product_pipe.sv
// Pipelined signed fixed-point dot product: multiply, adder tree, multi-beat accumulate,
// then round/saturate to one WIDTH-bit result per vector.
module fix_dot_product_pipe
   import fix_pkg::*;
#(
   parameter int unsigned LANES       = 8,
   parameter int unsigned WIDTH       = 16,
   parameter int unsigned POINT_WIDTH = 8,
   parameter int unsigned GUARD_BITS  = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*WIDTH-1:0] in_a,
   input  logic [LANES*WIDTH-1:0] in_b,
   input  logic                   in_last,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_sat
);

   localparam int unsigned PROD_W = 2 * WIDTH;
   localparam int unsigned TREE_W = tree_w(PROD_W, LANES);
   localparam int unsigned ACC_W  = acc_w(WIDTH, LANES, GUARD_BITS);

   if (LANES < 2 || LANES > 64 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
      $error("LANES must be a power of two in 2..64");
   end
   if (POINT_WIDTH < 1 || POINT_WIDTH > WIDTH - 1) begin : g_bad_point
      $error("POINT_WIDTH must be in 1..WIDTH-1");
   end
   if (ACC_W >= RS_W) begin : g_bad_acc
      $error("accumulator too wide for the shared rounding helper");
   end

   // Narrow the shared rounding result to this block's result width.
   function automatic logic [WIDTH:0] round_to_out(input logic signed [ACC_W-1:0] v);
      rs_t r;
      r = round_sat(RS_W'(v), POINT_WIDTH, WIDTH);
      return {r.sat, WIDTH'(r.data)};
   endfunction

   logic                      en;
   logic                      alive;
   logic                      m_valid;
   logic                      m_last;
   logic [LANES*PROD_W-1:0]   m_prod;
   logic                      t_valid;
   logic                      t_last;
   logic [TREE_W-1:0]         t_sum;
   logic signed [ACC_W-1:0]   acc;
   logic signed [ACC_W-1:0]   acc_base;
   logic signed [ACC_W-1:0]   t_ext;
   logic signed [ACC_W-1:0]   acc_nxt;
   logic                      mid;
   logic [WIDTH:0]            res;

   // A pending, unconsumed result freezes the whole pipeline.
   assign en       = !(out_valid && !out_ready);
   assign in_ready = en && alive;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alive <= 1'b0;
      else        alive <= 1'b1;
   end

   // Stage M: per-lane full-precision signed products.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_valid <= 1'b0;
         m_last  <= 1'b0;
         m_prod  <= '0;
      end else if (en) begin
         m_valid <= in_valid && alive;
         m_last  <= in_last;
         for (int i = 0; i < int'(LANES); i++) begin
            m_prod[i*PROD_W +: PROD_W] <= PROD_W'($signed(in_a[i*WIDTH +: WIDTH]))
                                        * PROD_W'($signed(in_b[i*WIDTH +: WIDTH]));
         end
      end
   end

   fix_add_tree #(
      .LANES (LANES),
      .IN_W  (PROD_W)
   ) u_tree (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .in_valid  (m_valid),
      .in_last   (m_last),
      .in_data   (m_prod),
      .out_valid (t_valid),
      .out_last  (t_last),
      .out_data  (t_sum)
   );

   // Next accumulator value; a new vector starts from zero.
   always_comb begin
      t_ext    = ACC_W'($signed(t_sum));
      acc_base = mid ? acc : '0;
      acc_nxt  = acc_base + t_ext;
      res      = round_to_out(acc_nxt);
   end

   // Stage A: accumulate, and on the last beat load the rounded result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc       <= '0;
         mid       <= 1'b0;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else if (en) begin
         if (t_valid) begin
            acc <= acc_nxt;
            mid <= !t_last;
         end
         if (t_valid && t_last) begin
            out_valid <= 1'b1;
            out_data  <= res[WIDTH-1:0];
            out_sat   <= res[WIDTH];
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_fix_dot_product_pipe.sv
// Bench for fix_dot_product_pipe: directed scenarios plus randomized vectors against an arithmetic model.
module tb_fix_dot_product_pipe;

   localparam int LANES = 8;
   localparam int WIDTH = 16;
   localparam int PW    = 8;

   logic                   clk = 1'b0;
   logic                   rst_n = 1'b0;
   logic                   in_valid = 1'b0;
   logic                   in_ready;
   logic [LANES*WIDTH-1:0] in_a = '0;
   logic [LANES*WIDTH-1:0] in_b = '0;
   logic                   in_last = 1'b0;
   logic                   out_valid;
   logic                   out_ready = 1'b1;
   logic [WIDTH-1:0]       out_data;
   logic                   out_sat;

   int vectors = 0;
   int miscompares = 0;

   int     obs_data[$];
   bit     obs_sat[$];
   int     exp_data[$];
   bit     exp_sat[$];
   longint cur_sum = 0;

   always #5 clk = ~clk;

   fix_dot_product_pipe #(
      .LANES       (LANES),
      .WIDTH       (WIDTH),
      .POINT_WIDTH (PW),
      .GUARD_BITS  (8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_sat   (out_sat)
   );

   // Record every result that will be consumed at the coming edge.
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         obs_data.push_back(int'($signed(out_data)));
         obs_sat.push_back(out_sat);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic void ref_result(input longint s, output int d, output bit sat);
      longint r;
      longint hi;
      longint lo;
      hi = (longint'(1) << (WIDTH - 1)) - 1;
      lo = -(longint'(1) << (WIDTH - 1));
      r = (s + (longint'(1) << (PW - 1))) >>> PW;
      sat = 1'b0;
      if (r > hi) begin r = hi; sat = 1'b1; end
      else if (r < lo) begin r = lo; sat = 1'b1; end
      d = int'(r);
   endfunction

   function automatic logic [LANES*WIDTH-1:0] pack(input int v[LANES]);
      logic [LANES*WIDTH-1:0] p;
      p = '0;
      for (int i = 0; i < LANES; i++) p[i*WIDTH +: WIDTH] = WIDTH'(v[i]);
      return p;
   endfunction

   function automatic void clear_queues();
      obs_data.delete(); obs_sat.delete(); exp_data.delete(); exp_sat.delete();
   endfunction

   // Present one beat until accepted; update the model on acceptance.
   task automatic send_beat(input int a[LANES], input int b[LANES], input bit last);
      bit acc_ok;
      int d;
      bit s;
      in_a = pack(a); in_b = pack(b); in_last = last; in_valid = 1'b1;
      acc_ok = 1'b0;
      for (int k = 0; k < 300; k++) begin
         @(negedge clk);
         if (in_ready) begin
            @(posedge clk);
            acc_ok = 1'b1;
            break;
         end
      end
      #1 in_valid = 1'b0;
      if (!acc_ok) begin
         vectors++; miscompares++;
         $display("FAIL beat_accept: in_ready=%0b, required 1 within 300 cycles", in_ready);
      end else begin
         for (int i = 0; i < LANES; i++) cur_sum += longint'(a[i]) * longint'(b[i]);
         if (last) begin
            ref_result(cur_sum, d, s);
            exp_data.push_back(d); exp_sat.push_back(s);
            cur_sum = 0;
         end
      end
   endtask

   task automatic wait_results(input int n, input int budget);
      int k;
      k = 0;
      while (obs_data.size() < n && k < budget) begin
         @(posedge clk); #1; k++;
      end
      if (obs_data.size() < n) begin
         vectors++; miscompares++;
         $display("FAIL result_timeout: got %0d results, required %0d", obs_data.size(), n);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #12;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid: %0b vs 0", out_valid); end
      vectors++; if (out_data !== '0) begin miscompares++; $display("FAIL reset_out_data: %0h vs 0", out_data); end
      vectors++; if (out_sat !== 1'b0) begin miscompares++; $display("FAIL reset_out_sat: %0b vs 0", out_sat); end
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready: %0b vs 0", in_ready); end
      @(negedge clk); rst_n = 1'b1;
      #1;
      vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL in_ready_before_clk: %0b vs 0", in_ready); end
      @(posedge clk); #1;
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL in_ready_after_clk: %0b vs 1", in_ready); end
   endtask

   task automatic test_single_beat();
      int a[LANES];
      int b[LANES];
      int k;
      clear_queues(); out_ready = 1'b1;
      for (int i = 0; i < LANES; i++) begin a[i] = 256; b[i] = 512; end
      send_beat(a, b, 1'b1);
      k = 0;
      for (int c = 1; c <= 10; c++) begin
         if (out_valid) break;
         @(posedge clk); #1; k = c;
      end
      vectors++; if (k != 4 || out_valid !== 1'b1) begin miscompares++; $display("FAIL latency: %0d cycles, required 4", k); end
      wait_results(1, 20);
      if (obs_data.size() >= 1) begin
         vectors++; if (obs_data[0] != 4096) begin miscompares++; $display("FAIL single_data: %0d vs 4096", obs_data[0]); end
         vectors++; if (obs_sat[0] != 1'b0) begin miscompares++; $display("FAIL single_sat: %0b vs 0", obs_sat[0]); end
      end
   endtask

   task automatic test_two_beat();
      int a[LANES];
      int b[LANES];
      clear_queues();
      for (int i = 0; i < LANES; i++) begin a[i] = 256; b[i] = 256; end
      send_beat(a, b, 1'b0);
      for (int i = 0; i < LANES; i++) begin a[i] = -256; b[i] = 128; end
      send_beat(a, b, 1'b1);
      repeat (12) begin @(posedge clk); #1; end
      vectors++; if (obs_data.size() != 1) begin miscompares++; $display("FAIL two_beat_count: %0d pulses vs 1", obs_data.size()); end
      if (obs_data.size() >= 1) begin
         vectors++; if (obs_data[0] != 1024) begin miscompares++; $display("FAIL two_beat_data: %0d vs 1024", obs_data[0]); end
      end
   endtask

   task automatic test_saturation();
      int a[LANES];
      int b[LANES];
      clear_queues();
      for (int i = 0; i < LANES; i++) begin a[i] = 32767; b[i] = 32767; end
      send_beat(a, b, 1'b1);
      for (int i = 0; i < LANES; i++) begin a[i] = -32768; b[i] = 32767; end
      send_beat(a, b, 1'b1);
      wait_results(2, 20);
      if (obs_data.size() >= 2) begin
         vectors++; if (obs_data[0] != 32767 || obs_sat[0] != 1'b1) begin miscompares++; $display("FAIL sat_pos: %0d/%0b vs 32767/1", obs_data[0], obs_sat[0]); end
         vectors++; if (obs_data[1] != -32768 || obs_sat[1] != 1'b1) begin miscompares++; $display("FAIL sat_neg: %0d/%0b vs -32768/1", obs_data[1], obs_sat[1]); end
      end
   endtask

   task automatic test_rounding();
      int a[LANES];
      int b[LANES];
      int av[3];
      int bv[3];
      int ev[3];
      av = '{1, -1, -1}; bv = '{128, 128, 384}; ev = '{1, 0, -1};
      clear_queues();
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < LANES; i++) begin a[i] = 0; b[i] = 0; end
         a[0] = av[t]; b[0] = bv[t];
         send_beat(a, b, 1'b1);
      end
      wait_results(3, 20);
      for (int t = 0; t < 3; t++) begin
         if (obs_data.size() > t) begin
            vectors++;
            if (obs_data[t] != ev[t] || obs_sat[t] != 1'b0) begin
               miscompares++;
               $display("FAIL round_%0d: %0d/%0b vs %0d/0", t, obs_data[t], obs_sat[t], ev[t]);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      int a[LANES];
      int b[LANES];
      int k;
      int ev[3];
      ev = '{256, 512, 768};
      clear_queues();
      out_ready = 1'b0;
      for (int t = 0; t < 3; t++) begin
         for (int i = 0; i < LANES; i++) begin a[i] = 256; b[i] = 32 * (t + 1); end
         send_beat(a, b, 1'b1);
      end
      k = 0;
      while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
      for (int c = 0; c < 10; c++) begin
         vectors++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1 || $signed(out_data) != 256) begin
            miscompares++;
            $display("FAIL stall_hold: in_ready=%0b out_valid=%0b out_data=%0d, required 0/1/256",
                     in_ready, out_valid, $signed(out_data));
         end
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      wait_results(3, 30);
      repeat (10) begin @(posedge clk); #1; end
      vectors++; if (obs_data.size() != 3) begin miscompares++; $display("FAIL bp_count: %0d results vs 3", obs_data.size()); end
      for (int t = 0; t < 3; t++) begin
         if (obs_data.size() > t) begin
            vectors++;
            if (obs_data[t] != ev[t]) begin miscompares++; $display("FAIL bp_order_%0d: %0d vs %0d", t, obs_data[t], ev[t]); end
         end
      end
   endtask

   task automatic test_reset_mid_vector();
      int a[LANES];
      int b[LANES];
      int k;
      clear_queues();
      out_ready = 1'b0;
      for (int i = 0; i < LANES; i++) begin a[i] = 256; b[i] = 256; end
      send_beat(a, b, 1'b1);
      send_beat(a, b, 1'b0);
      k = 0;
      while (!out_valid && k < 20) begin @(posedge clk); #1; k++; end
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL pre_reset_valid: %0b vs 1", out_valid); end
      #2 rst_n = 1'b0;
      #1;
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL async_reset_valid: %0b vs 0", out_valid); end
      vectors++; if (in_ready !== 1'b0 || out_data !== '0) begin miscompares++; $display("FAIL async_reset_state: in_ready=%0b out_data=%0h vs 0/0", in_ready, out_data); end
      cur_sum = 0;
      clear_queues();
      @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
      @(posedge clk); #1;
      for (int i = 0; i < LANES; i++) begin a[i] = 256; b[i] = 256; end
      send_beat(a, b, 1'b1);
      wait_results(1, 20);
      if (obs_data.size() >= 1) begin
         vectors++; if (obs_data[0] != 2048 || obs_sat[0] != 1'b0) begin miscompares++; $display("FAIL post_reset_data: %0d/%0b vs 2048/0", obs_data[0], obs_sat[0]); end
      end
   endtask

   task automatic test_random();
      int a[LANES];
      int b[LANES];
      int nb;
      logic [15:0] r16;
      clear_queues();
      cur_sum = 0;
      fork
         begin
            for (int v = 0; v < 25; v++) begin
               nb = $urandom_range(1, 4);
               for (int bt = 0; bt < nb; bt++) begin
                  repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                  for (int i = 0; i < LANES; i++) begin
                     if ($urandom_range(0, 3) == 0) begin r16 = 16'($urandom); a[i] = int'($signed(r16)); end
                     else a[i] = int'($urandom_range(0, 1023)) - 512;
                     if ($urandom_range(0, 3) == 0) begin r16 = 16'($urandom); b[i] = int'($signed(r16)); end
                     else b[i] = int'($urandom_range(0, 1023)) - 512;
                  end
                  send_beat(a, b, bt == nb - 1);
               end
            end
         end
         begin
            repeat (400) begin
               @(posedge clk); #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      out_ready = 1'b1;
      wait_results(exp_data.size(), 200);
      repeat (10) begin @(posedge clk); #1; end
      vectors++;
      if (obs_data.size() != exp_data.size()) begin
         miscompares++;
         $display("FAIL rand_count: %0d results vs %0d", obs_data.size(), exp_data.size());
      end
      for (int t = 0; t < exp_data.size() && t < obs_data.size(); t++) begin
         vectors++;
         if (obs_data[t] != exp_data[t] || obs_sat[t] != exp_sat[t]) begin
            miscompares++;
            $display("FAIL rand_%0d: %0d/%0b vs %0d/%0b", t, obs_data[t], obs_sat[t], exp_data[t], exp_sat[t]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_two_beat();
      test_saturation();
      test_rounding();
      test_backpressure();
      test_reset_mid_vector();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
